// File: rtl/flash_reader.sv
// rtl/flash_reader.sv - NOR flash word-mode read responder for the flash-load handshake
//
// Drives a 16-bit NOR flash in x16 word mode on behalf of the boot/load
// controller. Each read presents the captured half-word address, holds OE#
// low for ACCESS_CYCLES, samples the data bus, raises data_ready for
// READY_CYCLES and then forces a GAP_CYCLES low gap so the requester can
// advance its address exactly once per pulse.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   enable        high = back-to-back reads, low = go idle
//   req_addr      half-word address (byte address bits 22:1)
//   data_o        last half-word read
//   data_ready    data_o valid while high
//   flash_a       flash byte address {addr_q, 1'b0}
//   flash_d_i     flash data bus input half
//   flash_d_oe    data bus tristate enable (never drives)
//   flash_ce_n    chip enable, active low
//   flash_oe_n    output enable, active low
//   flash_we_n    write enable, held inactive
//   flash_rp_n    reset/power-down, active low
//   flash_byte_n  held high for x16 mode
//   flash_vpen    held low, programming disabled

module flash_reader #(
    parameter int ACCESS_CYCLES = 8,
    parameter int READY_CYCLES  = 2,
    parameter int GAP_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [21:0] req_addr,
    output logic [15:0] data_o,
    output logic        data_ready,
    output logic [22:0] flash_a,
    input  logic [15:0] flash_d_i,
    output logic        flash_d_oe,
    output logic        flash_ce_n,
    output logic        flash_oe_n,
    output logic        flash_we_n,
    output logic        flash_rp_n,
    output logic        flash_byte_n,
    output logic        flash_vpen
);

    localparam int MAX_AR     = (ACCESS_CYCLES > READY_CYCLES) ? ACCESS_CYCLES : READY_CYCLES;
    localparam int MAX_CYCLES = (MAX_AR > GAP_CYCLES) ? MAX_AR : GAP_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] ACCESS_LAST = CW'(ACCESS_CYCLES - 1);
    localparam logic [CW-1:0] READY_LAST  = CW'(READY_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_CYCLES - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] counter;
    logic [21:0]   addr_q;

    // Read-only, x16, programming locked out.
    assign flash_d_oe   = 1'b0;
    assign flash_we_n   = 1'b1;
    assign flash_byte_n = 1'b1;
    assign flash_vpen   = 1'b0;

    // Word address straight from the captured register; address wrap at the
    // top of the device needs no special handling.
    assign flash_a = {addr_q, 1'b0};

    // Pin levels for a state are registered on the edge that enters it, so
    // CE# is low during the SETUP cycle itself and OE# during every WAIT
    // cycle, giving the flash the full ACCESS_CYCLES of OE# before sampling.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            counter    <= '0;
            addr_q     <= '0;
            data_o     <= '0;
            data_ready <= 1'b0;
            flash_ce_n <= 1'b1;
            flash_oe_n <= 1'b1;
            flash_rp_n <= 1'b0;
        end else begin
            flash_rp_n <= 1'b1;
            case (state)
                S_IDLE: begin
                    data_ready <= 1'b0;
                    flash_oe_n <= 1'b1;
                    counter    <= '0;
                    if (enable) begin
                        state      <= S_SETUP;
                        addr_q     <= req_addr;
                        flash_ce_n <= 1'b0;
                    end else begin
                        flash_ce_n <= 1'b1;
                    end
                end

                S_SETUP: begin
                    counter <= '0;
                    if (!enable) begin
                        state      <= S_IDLE;
                        flash_ce_n <= 1'b1;
                        flash_oe_n <= 1'b1;
                    end else begin
                        state      <= S_WAIT;
                        flash_oe_n <= 1'b0;
                    end
                end

                S_WAIT: begin
                    if (!enable) begin
                        // Abandon the access; data_o keeps the previous word.
                        state      <= S_IDLE;
                        counter    <= '0;
                        flash_ce_n <= 1'b1;
                        flash_oe_n <= 1'b1;
                    end else if (counter == ACCESS_LAST) begin
                        state      <= S_HOLD;
                        counter    <= '0;
                        data_o     <= flash_d_i;
                        data_ready <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end

                S_HOLD: begin
                    // Losing enable cuts the pulse short but still goes
                    // through GAP so the requester always sees a low gap.
                    if (!enable || counter == READY_LAST) begin
                        state      <= S_GAP;
                        counter    <= '0;
                        data_ready <= 1'b0;
                        flash_ce_n <= 1'b1;
                        flash_oe_n <= 1'b1;
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end

                S_GAP: begin
                    if (counter == GAP_LAST) begin
                        counter <= '0;
                        if (enable) begin
                            // Requester has advanced during HOLD; take the
                            // new address as SETUP begins.
                            state      <= S_SETUP;
                            addr_q     <= req_addr;
                            flash_ce_n <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        counter <= counter + CW'(1);
                    end
                end

                default: begin
                    state      <= S_IDLE;
                    counter    <= '0;
                    data_ready <= 1'b0;
                    flash_ce_n <= 1'b1;
                    flash_oe_n <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_reader.sv
// tb/tb_flash_reader.sv - self-checking bench for flash_reader

module tb_flash_reader;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [21:0] req_addr;
    logic [15:0] data_o;
    logic        data_ready;
    logic [22:0] flash_a;
    logic [15:0] flash_d_i;
    logic        flash_d_oe;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;
    logic        flash_rp_n;
    logic        flash_byte_n;
    logic        flash_vpen;

    int checks;
    int failures;

    // Flash model: either a constant word or a keyed function of the address.
    logic        use_const;
    logic [15:0] const_data;
    logic [15:0] key;
    logic [15:0] model_data;

    always_comb begin
        flash_d_i = use_const ? const_data : (flash_a[16:1] ^ key);
    end

    flash_reader dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .req_addr     (req_addr),
        .data_o       (data_o),
        .data_ready   (data_ready),
        .flash_a      (flash_a),
        .flash_d_i    (flash_d_i),
        .flash_d_oe   (flash_d_oe),
        .flash_ce_n   (flash_ce_n),
        .flash_oe_n   (flash_oe_n),
        .flash_we_n   (flash_we_n),
        .flash_rp_n   (flash_rp_n),
        .flash_byte_n (flash_byte_n),
        .flash_vpen   (flash_vpen)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        int highs;
        enable = 1'b0;
        highs  = 0;
        repeat (20) begin
            tick();
            if (data_ready) highs++;
        end
        checks++;
        if (flash_ce_n !== 1'b1 || data_ready !== 1'b0) begin
            failures++;
            $display("FAIL idle_state ce_n=%b ready=%b exp ce_n=1 ready=0", flash_ce_n, data_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; req_addr = '0;
        use_const = 1'b1; const_data = 16'hBEEF; key = '0;
        repeat (3) tick();
        checks++;
        if (flash_rp_n !== 1'b0 || flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_pins rp_n=%b ce_n=%b oe_n=%b exp 0 1 1", flash_rp_n, flash_ce_n, flash_oe_n);
        end
        checks++;
        if (data_ready !== 1'b0 || data_o !== 16'h0000 || flash_a !== 23'h0) begin
            failures++;
            $display("FAIL reset_data ready=%b data_o=%h flash_a=%h exp 0 0000 0", data_ready, data_o, flash_a);
        end
        checks++;
        if (flash_d_oe !== 1'b0 || flash_we_n !== 1'b1 || flash_byte_n !== 1'b1 || flash_vpen !== 1'b0) begin
            failures++;
            $display("FAIL constants d_oe=%b we_n=%b byte_n=%b vpen=%b exp 0 1 1 0", flash_d_oe, flash_we_n, flash_byte_n, flash_vpen);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (flash_rp_n !== 1'b1) begin
            failures++;
            $display("FAIL reset_release rp_n=%b exp 1", flash_rp_n);
        end
        model_data = 16'h0000;
    endtask

    // Cycle c counts from the edge that samples enable in IDLE (edge 0).
    task automatic test_single();
        logic exp_oe, exp_ce, exp_rdy;
        logic [15:0] exp_d;
        use_const = 1'b1; const_data = 16'hA55A;
        req_addr = 22'h000123;
        enable = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 12) enable = 1'b0;
            exp_ce  = !(c >= 1 && c <= 11);
            exp_oe  = !(c >= 2 && c <= 11);
            exp_rdy = (c == 10 || c == 11);
            exp_d   = (c >= 10) ? 16'hA55A : model_data;
            checks++;
            if (flash_a !== 23'h000246) begin
                failures++;
                $display("FAIL single_addr cyc=%0d got=%h exp=000246", c, flash_a);
            end
            checks++;
            if (flash_ce_n !== exp_ce || flash_oe_n !== exp_oe) begin
                failures++;
                $display("FAIL single_strobes cyc=%0d ce_n=%b oe_n=%b exp %b %b", c, flash_ce_n, flash_oe_n, exp_ce, exp_oe);
            end
            checks++;
            if (data_ready !== exp_rdy || data_o !== exp_d) begin
                failures++;
                $display("FAIL single_data cyc=%0d ready=%b data_o=%h exp %b %h", c, data_ready, data_o, exp_rdy, exp_d);
            end
        end
        model_data = 16'hA55A;
        go_idle();
    endtask

    // Requester advances its address once per data_ready rising edge.
    task automatic test_streaming(input logic [21:0] start, input logic [15:0] k);
        int rises, last_rise;
        logic prev;
        logic [21:0] exp_addr;
        use_const = 1'b0; key = k;
        req_addr = start; enable = 1'b1;
        rises = 0; last_rise = 0; prev = 1'b0;
        for (int c = 1; c <= 80 && rises < 4; c++) begin
            tick();
            if (data_ready && !prev) begin
                exp_addr = start + 22'(rises);
                checks++;
                if (data_o !== (exp_addr[15:0] ^ k) || flash_a !== {exp_addr, 1'b0}) begin
                    failures++;
                    $display("FAIL stream_data n=%0d data_o=%h flash_a=%h exp %h %h", rises, data_o, flash_a, exp_addr[15:0] ^ k, {exp_addr, 1'b0});
                end
                checks++;
                if ((rises == 0 && c != 10) || (rises > 0 && c - last_rise != 13)) begin
                    failures++;
                    $display("FAIL stream_timing n=%0d cyc=%0d prev=%0d exp first=10 period=13", rises, c, last_rise);
                end
                model_data = exp_addr[15:0] ^ k;
                last_rise = c;
                rises++;
                req_addr = req_addr + 22'd1;
            end
            prev = data_ready;
        end
        checks++;
        if (rises != 4) begin
            failures++;
            $display("FAIL stream_count got=%0d exp=4", rises);
        end
        go_idle();
    endtask

    task automatic test_late_addr(input logic [15:0] k);
        use_const = 1'b0; key = k;
        req_addr = 22'd5; enable = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 3) req_addr = 22'd9;
            if (c == 10) begin
                checks++;
                if (data_ready !== 1'b1 || data_o !== (16'd5 ^ k)) begin
                    failures++;
                    $display("FAIL late_data ready=%b data_o=%h exp 1 %h", data_ready, data_o, 16'd5 ^ k);
                end
            end
            if (c >= 1 && c <= 13) begin
                checks++;
                if (flash_a !== 23'h00000A) begin
                    failures++;
                    $display("FAIL late_hold_addr cyc=%0d got=%h exp=00000a", c, flash_a);
                end
            end
            if (c == 14) begin
                checks++;
                if (flash_a !== 23'h000012 || flash_ce_n !== 1'b0) begin
                    failures++;
                    $display("FAIL late_next_addr flash_a=%h ce_n=%b exp 000012 0", flash_a, flash_ce_n);
                end
            end
        end
        model_data = 16'd5 ^ k;
        go_idle();
    endtask

    task automatic test_abort_wait();
        int highs;
        use_const = 1'b1; const_data = model_data ^ 16'hFFFF;
        req_addr = 22'($urandom); enable = 1'b1;
        repeat (4) tick();
        enable = 1'b0;
        tick();
        checks++;
        if (flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1 || data_ready !== 1'b0 || data_o !== model_data) begin
            failures++;
            $display("FAIL abort_wait ce_n=%b oe_n=%b ready=%b data_o=%h exp 1 1 0 %h", flash_ce_n, flash_oe_n, data_ready, data_o, model_data);
        end
        highs = 0;
        repeat (20) begin
            tick();
            if (data_ready !== 1'b0 || flash_ce_n !== 1'b1) highs++;
        end
        checks++;
        if (highs != 0 || data_o !== model_data) begin
            failures++;
            $display("FAIL abort_wait_idle active_cycles=%0d data_o=%h exp 0 %h", highs, data_o, model_data);
        end
    endtask

    task automatic test_abort_hold();
        int bad;
        logic [15:0] cd;
        cd = 16'($urandom);
        use_const = 1'b1; const_data = cd;
        req_addr = 22'($urandom); enable = 1'b1;
        repeat (10) tick();
        checks++;
        if (data_ready !== 1'b1 || data_o !== cd) begin
            failures++;
            $display("FAIL abort_hold_pulse ready=%b data_o=%h exp 1 %h", data_ready, data_o, cd);
        end
        model_data = cd;
        enable = 1'b0;
        bad = 0;
        for (int c = 11; c <= 30; c++) begin
            tick();
            if (data_ready !== 1'b0 || flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || data_o !== cd) begin
            failures++;
            $display("FAIL abort_hold_gap active_cycles=%0d data_o=%h exp 0 %h", bad, data_o, cd);
        end
    endtask

    task automatic test_reset_hold();
        int bad;
        use_const = 1'b1; const_data = 16'($urandom) | 16'h0001;
        req_addr = 22'($urandom); enable = 1'b1;
        repeat (10) tick();
        checks++;
        if (data_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_hold_pulse ready=%b exp 1", data_ready);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (data_ready !== 1'b0 || data_o !== 16'h0000 || flash_ce_n !== 1'b1 || flash_oe_n !== 1'b1 || flash_rp_n !== 1'b0 || flash_a !== 23'h0) begin
            failures++;
            $display("FAIL rst_hold ready=%b data_o=%h ce_n=%b oe_n=%b rp_n=%b flash_a=%h exp 0 0000 1 1 0 0", data_ready, data_o, flash_ce_n, flash_oe_n, flash_rp_n, flash_a);
        end
        rst = 1'b0; enable = 1'b0;
        bad = 0;
        repeat (15) begin
            tick();
            if (data_ready !== 1'b0 || flash_ce_n !== 1'b1 || flash_rp_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL rst_hold_idle bad_cycles=%0d exp 0", bad);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; enable = 1'b0; req_addr = '0;
        use_const = 1'b1; const_data = 16'hBEEF; key = '0; model_data = '0;
        test_reset();
        test_single();
        test_streaming(22'd0, 16'h0000);
        test_streaming(22'($urandom), 16'($urandom));
        test_streaming(22'h3FFFFE, 16'($urandom));
        test_late_addr(16'($urandom));
        test_abort_wait();
        test_abort_hold();
        test_reset_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
